pll_ctrl: RTL and testbench

//  Sequencer upstream of pll_sim: drives io_mul/io_bypass, qualifies io_lock, and holds
//  the PLL-clocked sub_module domain in reset until the output clock is stable.

---
 rtl/pll_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_pll_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pll_ctrl.sv
// PLL sequencer: programs multiplier, qualifies lock, gates the PLL-clocked reset.
// Optional PLLCTL_RELOCK_CNT_EN adds a saturating loss-of-lock counter port.
module pll_ctrl #(
    parameter int unsigned INIT_MUL      = 2,
    parameter int unsigned MUL_MAX       = 16,
    parameter int unsigned LOCK_BLANK    = 4,
    parameter int unsigned LOCK_TIMEOUT  = 1024,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned SWITCH_CYCLES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       io_req_valid,
    output logic       io_req_ready,
    input  logic [7:0] io_req_mul,
    input  logic       io_pll_lock,
    output logic       io_pll_bypass,
    output logic [7:0] io_pll_mul,
    output logic       io_core_reset,
    output logic       io_busy,
    output logic [7:0] io_cur_mul,
`ifdef PLLCTL_RELOCK_CNT_EN
    output logic [7:0] io_relock_cnt,
`endif
    output logic [1:0] io_err
);

    localparam int CW = 16;
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_RUN,
        S_BYPASS,
        S_PROGRAM,
        S_BLANK,
        S_WAIT_LOCK,
        S_SETTLE,
        S_UNBYPASS,
        S_FAIL
    } state_e;

    state_e      state_q, state_d;
    logic        bypass_q, bypass_d;
    logic [7:0]  pll_mul_q, pll_mul_d;
    logic        core_rst_q, core_rst_d;
    logic [7:0]  cur_mul_q, cur_mul_d;
    logic [1:0]  err_q, err_d;
    logic [7:0]  new_mul_q, new_mul_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        sync1_q, sync2_q;

    logic lock_s;
    logic take;
    logic req_bad;

    assign lock_s  = sync2_q;
    assign take    = io_req_valid & ready_q;
    assign req_bad = (io_req_mul == 8'd0) || (io_req_mul > 8'(MUL_MAX));

    always_comb begin
        state_d    = state_q;
        bypass_d   = bypass_q;
        pll_mul_d  = pll_mul_q;
        core_rst_d = core_rst_q;
        cur_mul_d  = cur_mul_q;
        err_d      = err_q;
        new_mul_d  = new_mul_q;
        cnt_d      = cnt_q;
        timer_d    = timer_q;

        unique case (state_q)
            S_RUN: begin
                if (!lock_s) begin
                    // loss of lock wins over any request this cycle
                    state_d    = S_BLANK;
                    core_rst_d = 1'b1;
                    bypass_d   = 1'b1;
                    cnt_d      = '0;
                end else if (take && io_req_mul != pll_mul_q) begin
                    if (req_bad) begin
                        err_d[1] = 1'b1;
                    end else begin
                        new_mul_d  = io_req_mul;
                        err_d      = 2'b00;
                        core_rst_d = 1'b1;
                        state_d    = S_BYPASS;
                    end
                end
            end
            S_BYPASS: begin
                bypass_d = 1'b1;
                state_d  = S_PROGRAM;
            end
            S_PROGRAM: begin
                pll_mul_d = new_mul_q;
                cnt_d     = '0;
                state_d   = S_BLANK;
            end
            S_BLANK: begin
                if (cnt_q == CW'(LOCK_BLANK - 1)) begin
                    cnt_d   = '0;
                    timer_d = '0;
                    state_d = S_WAIT_LOCK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_LOCK: begin
                if (lock_s) begin
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end else if (timer_q == TW'(LOCK_TIMEOUT - 1)) begin
                    err_d[0]   = 1'b1;
                    bypass_d   = 1'b1;
                    core_rst_d = 1'b0;
                    state_d    = S_FAIL;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_SETTLE: begin
                // timer keeps running across lock glitches
                if (!lock_s) begin
                    state_d = S_WAIT_LOCK;
                end else if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
                    cnt_d     = '0;
                    bypass_d  = 1'b0;
                    cur_mul_d = pll_mul_q;
                    state_d   = S_UNBYPASS;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_UNBYPASS: begin
                if (cnt_q == CW'(SWITCH_CYCLES - 1)) begin
                    cnt_d      = '0;
                    core_rst_d = 1'b0;
                    state_d    = S_RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FAIL: begin
                if (take) begin
                    if (req_bad) begin
                        err_d[1] = 1'b1;
                    end else begin
                        new_mul_d  = io_req_mul;
                        err_d      = 2'b00;
                        core_rst_d = 1'b1;
                        state_d    = S_BYPASS;
                    end
                end
            end
            default: state_d = S_BLANK;
        endcase

        ready_d = (state_d == S_RUN) || (state_d == S_FAIL);
        busy_d  = !ready_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_BLANK;
            bypass_q   <= 1'b1;
            pll_mul_q  <= 8'(INIT_MUL);
            core_rst_q <= 1'b1;
            cur_mul_q  <= 8'(INIT_MUL);
            err_q      <= 2'b00;
            new_mul_q  <= 8'(INIT_MUL);
            cnt_q      <= '0;
            timer_q    <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bypass_q   <= bypass_d;
            pll_mul_q  <= pll_mul_d;
            core_rst_q <= core_rst_d;
            cur_mul_q  <= cur_mul_d;
            err_q      <= err_d;
            new_mul_q  <= new_mul_d;
            cnt_q      <= cnt_d;
            timer_q    <= timer_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            sync1_q    <= io_pll_lock;
            sync2_q    <= sync1_q;
        end
    end

`ifdef PLLCTL_RELOCK_CNT_EN
    logic [7:0] relock_q, relock_d;

    always_comb begin
        relock_d = relock_q;
        if (state_q == S_RUN && !lock_s && relock_q != 8'hFF) begin
            relock_d = relock_q + 8'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            relock_q <= 8'd0;
        end else begin
            relock_q <= relock_d;
        end
    end

    assign io_relock_cnt = relock_q;
`endif

    assign io_req_ready  = ready_q;
    assign io_busy       = busy_q;
    assign io_pll_bypass = bypass_q;
    assign io_pll_mul    = pll_mul_q;
    assign io_core_reset = core_rst_q;
    assign io_cur_mul    = cur_mul_q;
    assign io_err        = err_q;

endmodule

// File: tb/tb_pll_ctrl.sv
// Directed bench for pll_ctrl: power-up, requests, timeout, loss of lock, reset.
// Lock input is driven directly; LOCK_TIMEOUT shortened to 64.
module tb_pll_ctrl;

    logic       clock;
    logic       reset;
    logic       io_req_valid;
    logic       io_req_ready;
    logic [7:0] io_req_mul;
    logic       io_pll_lock;
    logic       io_pll_bypass;
    logic [7:0] io_pll_mul;
    logic       io_core_reset;
    logic       io_busy;
    logic [7:0] io_cur_mul;
    logic [1:0] io_err;
`ifdef PLLCTL_RELOCK_CNT_EN
    logic [7:0] io_relock_cnt;
`endif

    int checks = 0;
    int errors = 0;

    pll_ctrl #(.LOCK_TIMEOUT(64)) dut (
        .clock(clock),
        .reset(reset),
        .io_req_valid(io_req_valid),
        .io_req_ready(io_req_ready),
        .io_req_mul(io_req_mul),
        .io_pll_lock(io_pll_lock),
        .io_pll_bypass(io_pll_bypass),
        .io_pll_mul(io_pll_mul),
        .io_core_reset(io_core_reset),
        .io_busy(io_busy),
        .io_cur_mul(io_cur_mul),
`ifdef PLLCTL_RELOCK_CNT_EN
        .io_relock_cnt(io_relock_cnt),
`endif
        .io_err(io_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] mul;
        logic [1:0] err;
        logic [7:0] pll_mul;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_run(input string name, input int budget);
        int n;
        n = 0;
        while (io_busy && n < budget) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (io_busy) begin
            errors++;
            $display("FAIL %s timeout after %0d cycles", name, budget);
        end
    endtask

    task automatic request(input logic [7:0] m);
        io_req_valid = 1'b1;
        io_req_mul   = m;
        tick(1);
        io_req_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{mul: 8'd2,   err: 2'b00, pll_mul: 8'd2};
        vecs[1] = '{mul: 8'd0,   err: 2'b10, pll_mul: 8'd2};
        vecs[2] = '{mul: 8'd17,  err: 2'b10, pll_mul: 8'd2};
        vecs[3] = '{mul: 8'd255, err: 2'b10, pll_mul: 8'd2};

        reset        = 1'b1;
        io_req_valid = 1'b0;
        io_req_mul   = 8'd0;
        io_pll_lock  = 1'b0;
        tick(5);
        chk("rst_bypass", int'(io_pll_bypass), 1);
        chk("rst_core", int'(io_core_reset), 1);
        chk("rst_mul", int'(io_pll_mul), 2);
        chk("rst_cur", int'(io_cur_mul), 2);
        chk("rst_err", int'(io_err), 0);
        chk("rst_busy", int'(io_busy), 1);
        chk("rst_ready", int'(io_req_ready), 0);
        reset = 1'b0;

        // power-up: lock arrives while in WAIT_LOCK
        tick(20);
        chk("pu_wait_busy", int'(io_busy), 1);
        chk("pu_wait_byp", int'(io_pll_bypass), 1);
        io_pll_lock = 1'b1;
        tick(18);
        chk("pu_settle_byp", int'(io_pll_bypass), 1);
        tick(1);
        chk("pu_unbyp_byp", int'(io_pll_bypass), 0);
        chk("pu_unbyp_core", int'(io_core_reset), 1);
        tick(1);
        chk("pu_sw_core", int'(io_core_reset), 1);
        tick(1);
        chk("pu_run_core", int'(io_core_reset), 0);
        chk("pu_run_busy", int'(io_busy), 0);
        chk("pu_run_ready", int'(io_req_ready), 1);
        chk("pu_run_cur", int'(io_cur_mul), 2);

        for (int i = 0; i < 4; i++) begin
            request(vecs[i].mul);
            chk($sformatf("vec%0d_err", i), int'(io_err), int'(vecs[i].err));
            chk($sformatf("vec%0d_mul", i), int'(io_pll_mul), int'(vecs[i].pll_mul));
            chk($sformatf("vec%0d_busy", i), int'(io_busy), 0);
            chk($sformatf("vec%0d_ready", i), int'(io_req_ready), 1);
        end

        // good change clears the sticky error
        request(8'd3);
        chk("chg3_err", int'(io_err), 0);
        chk("chg3_core", int'(io_core_reset), 1);
        chk("chg3_byp0", int'(io_pll_bypass), 0);
        chk("chg3_mul0", int'(io_pll_mul), 2);
        tick(1);
        chk("chg3_byp1", int'(io_pll_bypass), 1);
        chk("chg3_mul1", int'(io_pll_mul), 2);
        tick(1);
        chk("chg3_mul2", int'(io_pll_mul), 3);
        chk("chg3_cur2", int'(io_cur_mul), 2);
        wait_run("chg3_run", 100);
        chk("chg3_cur", int'(io_cur_mul), 3);
        chk("chg3_core_end", int'(io_core_reset), 0);
        chk("chg3_byp_end", int'(io_pll_bypass), 0);

        // loss of lock with a coincident request, then lock timeout
        io_pll_lock = 1'b0;
        tick(2);
        chk("lol_core_early", int'(io_core_reset), 0);
        io_req_valid = 1'b1;
        io_req_mul   = 8'd5;
        tick(1);
        io_req_valid = 1'b0;
        chk("lol_core", int'(io_core_reset), 1);
        chk("lol_byp", int'(io_pll_bypass), 1);
        chk("lol_busy", int'(io_busy), 1);
        chk("lol_mul", int'(io_pll_mul), 3);
        chk("lol_err", int'(io_err), 0);
`ifdef PLLCTL_RELOCK_CNT_EN
        chk("lol_relock", int'(io_relock_cnt), 1);
`endif
        tick(67);
        chk("to_pre_busy", int'(io_busy), 1);
        tick(1);
        chk("to_busy", int'(io_busy), 0);
        chk("to_ready", int'(io_req_ready), 1);
        chk("to_err", int'(io_err), 1);
        chk("to_byp", int'(io_pll_bypass), 1);
        chk("to_core", int'(io_core_reset), 0);

        request(8'd20);
        chk("fail_bad_err", int'(io_err), 3);
        chk("fail_bad_busy", int'(io_busy), 0);
        chk("fail_bad_mul", int'(io_pll_mul), 3);

        io_pll_lock = 1'b1;
        request(8'd2);
        chk("retry_err", int'(io_err), 0);
        chk("retry_core", int'(io_core_reset), 1);
        chk("retry_busy", int'(io_busy), 1);
        tick(2);
        chk("retry_mul", int'(io_pll_mul), 2);
        wait_run("retry_run", 100);
        chk("retry_cur", int'(io_cur_mul), 2);
        chk("retry_byp", int'(io_pll_bypass), 0);
        chk("retry_core_end", int'(io_core_reset), 0);

        request(8'd4);
        wait_run("chg4_run", 100);
        chk("chg4_cur", int'(io_cur_mul), 4);

        // reset asserted while settling on mul=5
        request(8'd5);
        tick(10);
        chk("mid_mul", int'(io_pll_mul), 5);
        chk("mid_byp", int'(io_pll_bypass), 1);
        reset = 1'b1;
        #1;
        chk("mr_byp", int'(io_pll_bypass), 1);
        chk("mr_core", int'(io_core_reset), 1);
        chk("mr_mul", int'(io_pll_mul), 2);
        chk("mr_cur", int'(io_cur_mul), 2);
        chk("mr_err", int'(io_err), 0);
        chk("mr_busy", int'(io_busy), 1);
        tick(1);
        reset = 1'b0;
        wait_run("mr_run", 100);
        chk("mr_run_cur", int'(io_cur_mul), 2);
        chk("mr_run_core", int'(io_core_reset), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
